usb_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the dual-port endpoint buffer memory in the USB buffers path. It owns the write and read pointers and the occupancy count, drives the memory's write enable and both address ports, and gives requesters full/empty status, a read-data-valid strobe, and error pulses. The memory's synchronous read, with one cycle of latency, is assumed. Both memory clock inputs are tied to this block's clock.

---
 rtl/usb_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_usb_fifo_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_ctrl.sv
// Pointer/occupancy controller for the dual-port endpoint buffer memory (synchronous read, 1-cycle latency).
// Optional almostFull/almostEmpty flags are built when USB_FIFO_CTRL_ALMOST_EN is defined.
module usb_fifo_ctrl #(
  parameter int FIFO_DEPTH       = 64,
  parameter int ADDR_WIDTH       = 6,
  parameter int ALMOST_FULL_LVL  = 60,
  parameter int ALMOST_EMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifoWEn,
  input  logic                  fifoREn,
  input  logic                  flush,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddrIn,
  output logic [ADDR_WIDTH-1:0] memAddrOut,
  output logic                  rdDataValid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   numElements,
  output logic                  wrErr,
  output logic                  rdErr
`ifdef USB_FIFO_CTRL_ALMOST_EN
  ,
  output logic                  almostFull,
  output logic                  almostEmpty
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifoState_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = FIFO_DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wrPtr, wrPtrNext;
  logic [ADDR_WIDTH-1:0] rdPtr, rdPtrNext;
  logic [ADDR_WIDTH:0]   count, countNext;
  logic                  rdDataValidNext, wrErrNext, rdErrNext;
  logic                  wrAcc, rdAcc;
  fifoState_e            state;

  // The FIFO state is never stored separately; it is decoded from the occupancy count.
  always_comb begin
    state = PARTIAL;
    if (count == '0) begin
      state = EMPTY;
    end else if (count == DEPTH_CNT) begin
      state = FULL;
    end
  end

  assign full        = (state == FULL);
  assign empty       = (state == EMPTY);
  assign numElements = count;

  // A write at full is only legal when a read frees the same slot in the same cycle.
  assign rdAcc = fifoREn & ~flush & ~empty;
  assign wrAcc = fifoWEn & ~flush & (~full | rdAcc);

  assign memWrEn    = wrAcc;
  assign memAddrIn  = wrPtr;
  assign memAddrOut = rdPtr;

  always_comb begin
    wrPtrNext       = wrPtr;
    rdPtrNext       = rdPtr;
    countNext       = count;
    rdDataValidNext = rdAcc;
    wrErrNext       = fifoWEn & full & ~rdAcc & ~flush;
    rdErrNext       = fifoREn & empty & ~flush;
    if (flush) begin
      wrPtrNext       = '0;
      rdPtrNext       = '0;
      countNext       = '0;
      rdDataValidNext = 1'b0;
    end else begin
      if (wrAcc) begin
        wrPtrNext = wrPtr + 1'b1;
      end
      if (rdAcc) begin
        rdPtrNext = rdPtr + 1'b1;
      end
      case ({wrAcc, rdAcc})
        2'b10:   countNext = count + 1'b1;
        2'b01:   countNext = count - 1'b1;
        default: countNext = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      rdDataValid <= 1'b0;
      wrErr       <= 1'b0;
      rdErr       <= 1'b0;
    end else begin
      wrPtr       <= wrPtrNext;
      rdPtr       <= rdPtrNext;
      count       <= countNext;
      rdDataValid <= rdDataValidNext;
      wrErr       <= wrErrNext;
      rdErr       <= rdErrNext;
    end
  end

`ifdef USB_FIFO_CTRL_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = ALMOST_FULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT = ALMOST_EMPTY_LVL[ADDR_WIDTH:0];

  assign almostFull  = (count >= AF_CNT);
  assign almostEmpty = (count <= AE_CNT);
`else
  // Thresholds have no effect without the almost flags.
  wire unusedLvls = (ALMOST_FULL_LVL > ALMOST_EMPTY_LVL);
`endif

endmodule

// File: tb/tb_usb_fifo_ctrl.sv
// Bench for usb_fifo_ctrl: behavioural memory plus a queue-based reference model of the FIFO.
// Checks the almost flags too when USB_FIFO_CTRL_ALMOST_EN is defined.
`timescale 1ns/1ps
module tb_usb_fifo_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifoWEn, fifoREn, flush;
  logic          memWrEn;
  logic [AW-1:0] memAddrIn, memAddrOut;
  logic          rdDataValid, full, empty, wrErr, rdErr;
  logic [AW:0]   numElements;
`ifdef USB_FIFO_CTRL_ALMOST_EN
  logic          almostFull, almostEmpty;
`endif

  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic [7:0] mem [DEPTH];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: contents in FIFO order plus the registered outputs expected after each edge.
  logic [7:0] refQ[$];
  int         mWrPtr, mRdPtr;
  logic       expValid, expWrErr, expRdErr;
  logic [7:0] expData;

  usb_fifo_ctrl #(
    .FIFO_DEPTH(64),
    .ADDR_WIDTH(6),
    .ALMOST_FULL_LVL(60),
    .ALMOST_EMPTY_LVL(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifoWEn(fifoWEn),
    .fifoREn(fifoREn),
    .flush(flush),
    .memWrEn(memWrEn),
    .memAddrIn(memAddrIn),
    .memAddrOut(memAddrOut),
    .rdDataValid(rdDataValid),
    .full(full),
    .empty(empty),
    .numElements(numElements),
    .wrErr(wrErr),
    .rdErr(rdErr)
`ifdef USB_FIFO_CTRL_ALMOST_EN
    ,
    .almostFull(almostFull),
    .almostEmpty(almostEmpty)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port buffer with synchronous read; a same-address write returns the old word.
  always @(posedge clk) begin
    if (memWrEn) mem[memAddrIn] <= dataIn;
    dataOut <= mem[memAddrOut];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegistered();
    int n;
    n = refQ.size();
    checkOutput("numElements", 32'(numElements), n);
    checkOutput("full", 32'(full), 32'(n == DEPTH));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("rdDataValid", 32'(rdDataValid), 32'(expValid));
    if (expValid) checkOutput("dataOut", 32'(dataOut), 32'(expData));
    checkOutput("wrErr", 32'(wrErr), 32'(expWrErr));
    checkOutput("rdErr", 32'(rdErr), 32'(expRdErr));
`ifdef USB_FIFO_CTRL_ALMOST_EN
    checkOutput("almostFull", 32'(almostFull), 32'(n >= 60));
    checkOutput("almostEmpty", 32'(almostEmpty), 32'(n <= 4));
`endif
  endtask

  task automatic resetModel();
    refQ.delete();
    mWrPtr   = 0;
    mRdPtr   = 0;
    expValid = 1'b0;
    expWrErr = 1'b0;
    expRdErr = 1'b0;
    expData  = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, update the model at the rising edge, check again.
  task automatic applyStimulus(input logic w, input logic r, input logic f, input logic [7:0] d);
    logic rdAccM, wrAccM;
    int   n;
    fifoWEn = w;
    fifoREn = r;
    flush   = f;
    dataIn  = d;
    n       = refQ.size();
    rdAccM  = r && !f && (n != 0);
    wrAccM  = w && !f && ((n != DEPTH) || rdAccM);
    #1;
    checkOutput("memWrEn", 32'(memWrEn), 32'(wrAccM));
    checkOutput("memAddrIn", 32'(memAddrIn), mWrPtr);
    checkOutput("memAddrOut", 32'(memAddrOut), mRdPtr);
    @(posedge clk);
    expWrErr = w && !f && (n == DEPTH) && !rdAccM;
    expRdErr = r && !f && (n == 0);
    if (f) begin
      refQ.delete();
      mWrPtr   = 0;
      mRdPtr   = 0;
      expValid = 1'b0;
    end else begin
      expValid = rdAccM;
      if (rdAccM) begin
        expData = refQ.pop_front();
        mRdPtr  = (mRdPtr + 1) % DEPTH;
      end
      if (wrAccM) begin
        refQ.push_back(d);
        mWrPtr = (mWrPtr + 1) % DEPTH;
      end
    end
    @(negedge clk);
    checkRegistered();
  endtask

  initial begin
    rst_n   = 1'b0;
    fifoWEn = 1'b0;
    fifoREn = 1'b0;
    flush   = 1'b0;
    dataIn  = '0;
    resetModel();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("[TB] reset state");
    checkRegistered();
    checkOutput("rst_memWrEn", 32'(memWrEn), 0);
    checkOutput("rst_memAddrIn", 32'(memAddrIn), 0);
    checkOutput("rst_memAddrOut", 32'(memAddrOut), 0);
    #1;

    $display("[TB] three writes then three reads");
    applyStimulus(1, 0, 0, 8'hA1);
    applyStimulus(1, 0, 0, 8'hA2);
    applyStimulus(1, 0, 0, 8'hA3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] fill to full, then overflow write");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 8'($urandom));
    applyStimulus(1, 0, 0, 8'hEE);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] simultaneous read/write at full across wrap");
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 8'($urandom));

    $display("[TB] drain, then simultaneous read/write at empty");
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h5C);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] flush with a pending read");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 8'($urandom));
    applyStimulus(0, 1, 1, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 2, 8'($urandom));
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 2, 8'($urandom));

`ifdef USB_FIFO_CTRL_ALMOST_EN
    $display("[TB] almost thresholds");
    applyStimulus(0, 0, 1, 8'h00);
    for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 56; i++) applyStimulus(0, 1, 0, 8'h00);
`endif

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 8'($urandom));
    applyStimulus(0, 1, 0, 8'h00);
    fifoWEn = 1'b0;
    fifoREn = 1'b0;
    flush   = 1'b0;
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkRegistered();
    checkOutput("arst_memWrEn", 32'(memWrEn), 0);
    checkOutput("arst_memAddrIn", 32'(memAddrIn), 0);
    checkOutput("arst_memAddrOut", 32'(memAddrOut), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    applyStimulus(1, 0, 0, 8'h77);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
